// File: rtl/coin_renderer.sv
// coin_renderer
// Reads the 10-entry coin memory once per frame tick and paints a W x L block
// for every entry through the VGA adapter plot interface. Live coins use
// COIN_COLOUR; erased coins are overdrawn in BG_COLOUR (or skipped when
// ERASE_ABSENT=0). The number of live coins is published at the end of a pass.
//
// Ports:
//   clock        system clock, all logic on posedge
//   resetn       synchronous active-low reset
//   start        one-cycle frame tick, accepted only while idle
//   mem_q        coin word from RAM: [15]=exists, [14:7]=x, [6:0]=y
//   mem_address  coin RAM read address (RAM has a one-cycle read latency)
//   x, y, colour pixel coordinates and colour, aligned with plot
//   plot         pixel write strobe, at most one pixel per cycle
//   busy         high in every state except IDLE
//   done         one-cycle pulse in the DONE state
//   coins_left   exists=1 count from the last completed pass
//   dbg_state    current FSM state
//
// Handshake: start is a fire-and-forget pulse with no ready; it is taken only
// on a cycle where the FSM is in IDLE, otherwise it is dropped. plot has no
// backpressure: the adapter must accept a pixel on every cycle plot is high.
module coin_renderer #(
    parameter int          W            = 4,
    parameter int          L            = 4,
    parameter int          NUM_COINS    = 10,
    parameter logic [2:0]  COIN_COLOUR  = 3'b110,
    parameter logic [2:0]  BG_COLOUR    = 3'b000,
    parameter int          ERASE_ABSENT = 1,
    parameter int          X_MAX        = 159,
    parameter int          Y_MAX        = 119
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [15:0] mem_q,
    output logic [4:0]  mem_address,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done,
    output logic [3:0]  coins_left,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0] state;
    logic [3:0] idx;
    logic [3:0] live;
    logic       coin_exists;
    logic [7:0] cx;
    logic [6:0] cy;
    logic [2:0] px;
    logic [2:0] py;

    logic       px_last;
    logic       py_last;
    logic [2:0] nx_px;
    logic [2:0] nx_py;

    // Source of the pixel registered at the next edge: in FETCH it is the
    // first pixel of the word arriving on mem_q, in DRAW it is the next pixel
    // of the latched coin.
    logic       src_ex;
    logic [7:0] src_cx;
    logic [6:0] src_cy;
    logic [2:0] src_px;
    logic [2:0] src_py;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       in_range;
    logic [2:0] src_colour;

    assign dbg_state = state;

    assign px_last = (px == 3'(W - 1));
    assign py_last = (py == 3'(L - 1));
    assign nx_px   = px_last ? 3'd0 : px + 3'd1;
    assign nx_py   = px_last ? py + 3'd1 : py;

    always_comb begin
        src_ex = coin_exists;
        src_cx = cx;
        src_cy = cy;
        src_px = nx_px;
        src_py = nx_py;
        if (state == S_FETCH) begin
            src_ex = mem_q[15];
            src_cx = mem_q[14:7];
            src_cy = mem_q[6:0];
            src_px = 3'd0;
            src_py = 3'd0;
        end
        // Widened sums so pixels running off the right/bottom edge are
        // detected instead of wrapping onto the screen.
        sum_x      = {1'b0, src_cx} + {6'b0, src_px};
        sum_y      = {1'b0, src_cy} + {5'b0, src_py};
        in_range   = (sum_x <= 9'(X_MAX)) && (sum_y <= 8'(Y_MAX));
        src_colour = src_ex ? COIN_COLOUR : BG_COLOUR;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= S_IDLE;
            idx         <= 4'd0;
            live        <= 4'd0;
            coin_exists <= 1'b0;
            cx          <= 8'd0;
            cy          <= 7'd0;
            px          <= 3'd0;
            py          <= 3'd0;
            mem_address <= 5'd0;
            x           <= 8'd0;
            y           <= 7'd0;
            colour      <= 3'd0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            coins_left  <= 4'd0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state       <= S_ADDR;
                        idx         <= 4'd0;
                        live        <= 4'd0;
                        mem_address <= 5'd0;
                        busy        <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    coin_exists <= mem_q[15];
                    cx          <= mem_q[14:7];
                    cy          <= mem_q[6:0];
                    if (mem_q[15]) begin
                        live <= live + 4'd1;
                    end
                    if (mem_q[15] || (ERASE_ABSENT != 0)) begin
                        state  <= S_DRAW;
                        px     <= 3'd0;
                        py     <= 3'd0;
                        x      <= sum_x[7:0];
                        y      <= sum_y[6:0];
                        colour <= src_colour;
                        plot   <= in_range;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_DRAW: begin
                    // The pixel for (px,py) is already on the outputs this
                    // cycle; only advance if it was not the last one.
                    if (px_last && py_last) begin
                        state <= S_NEXT;
                    end else begin
                        px     <= nx_px;
                        py     <= nx_py;
                        x      <= sum_x[7:0];
                        y      <= sum_y[6:0];
                        colour <= src_colour;
                        plot   <= in_range;
                    end
                end
                S_NEXT: begin
                    if (idx == 4'(NUM_COINS - 1)) begin
                        state      <= S_DONE;
                        done       <= 1'b1;
                        coins_left <= live;
                    end else begin
                        idx         <= idx + 4'd1;
                        mem_address <= {1'b0, idx + 4'd1};
                        state       <= S_ADDR;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/coin_renderer.md
Name: coin_renderer

Overview:
- Reader side of the 10-entry coin memory that the point counter scans and erases.
- On each frame tick, walks entries 0..9 and emits one W x L pixel block per coin to the VGA adapter plot interface.
- Existing coins are drawn in COIN_COLOUR; erased coins (exists=0) are overdrawn in BG_COLOUR so collected coins disappear from the screen.
- Reports the number of live coins at the end of each pass.

Parameters:
- W, 4, coin width in pixels (x extent), 1..8
- L, 4, coin height in pixels (y extent), 1..8
- NUM_COINS, 10, entries scanned, addresses 0..NUM_COINS-1
- COIN_COLOUR, 3'b110, colour for existing coins
- BG_COLOUR, 3'b000, colour used to overdraw erased coins
- ERASE_ABSENT, 1, 1 = overdraw entries with exists=0; 0 = skip them
- X_MAX, 159, largest on-screen x
- Y_MAX, 119, largest on-screen y

Ports:
- clock  in  1  system clock, all logic on posedge
- resetn  in  1  synchronous active-low reset
- start  in  1  one-cycle frame tick; starts a pass when idle
- mem_q  in  16  coin word: [15]=exists, [14:7]=x, [6:0]=y
- mem_address  out  5  coin memory read address
- x  out  8  pixel x to VGA adapter
- y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe, one pixel per cycle
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse at end of pass
- coins_left  out  4  count of exists=1 entries in the last completed pass

Behaviour:
- Reset (sync, resetn=0 at posedge):
  - state=IDLE; mem_address=0, x=0, y=0, colour=0, plot=0, busy=0, done=0, coins_left=0.
  - Reset mid-pass aborts immediately; no further plot pulses are issued.
- Memory: synchronous read. mem_address is registered by the RAM at the clock edge; mem_q is valid the following cycle. The block never writes the memory.
- States:
  - IDLE: busy=0. On start=1, go to ADDR with idx=0 and live count=0.
  - ADDR: mem_address=idx. Go to FETCH.
  - FETCH: latch mem_q into coin register. If exists=1, increment live count.
    - If exists=1 or ERASE_ABSENT=1: go to DRAW with px=0, py=0.
    - Otherwise: go to NEXT.
  - DRAW: one pixel per cycle.
    - x=cx+px, y=cy+py; colour=COIN_COLOUR if exists, else BG_COLOUR.
    - px increments 0..W-1; on px=W-1, px returns to 0 and py increments.
    - After px=W-1 and py=L-1, go to NEXT. DRAW lasts exactly W*L cycles.
  - NEXT: if idx=NUM_COINS-1, go to DONE; else idx+1 and go to ADDR.
  - DONE: done=1 for one cycle; coins_left <= live count; go to IDLE.
- Outputs:
  - Registered; plot/x/y/colour are aligned to the same cycle.
  - busy=1 in every state except IDLE, including DONE.
- Clipping:
  - Sums are computed at 9 bits for x and 8 bits for y.
  - If cx+px > X_MAX or cy+py > Y_MAX, that cycle has plot=0, with x/y showing the truncated low bits. Cycle count is unchanged.
- start while busy is ignored, including during DONE. start in the same cycle the block returns to IDLE is not seen; it is taken on the next cycle only if it is still asserted.
- Timing: drawn entry = 3 + W*L cycles (ADDR, FETCH, DRAW, NEXT); skipped entry = 3 cycles.
  - Full pass with defaults and all entries drawn = 10*19 + 1 = 191 cycles from first ADDR to DONE inclusive.
- coins_left holds its value between passes and updates only in DONE.

Test Plan:
- Reset, then start with all 10 words = 16'h8514 (x=10, y=20) -> 160 plot pulses; first pixel (10,20), last (13,23), colour 110. done pulses once, 191 cycles after ADDR entry. coins_left=10.
- Entry 3 = 16'h0514, others 16'h0000, ERASE_ABSENT=1 -> all 160 pixels colour 000; coins_left=0. Rerun with ERASE_ABSENT=0 -> zero plot pulses, pass length 31 cycles.
- Entry 0 = 16'hD35F (x=166, y=95), others 16'h8514 -> entry 0 produces 16 cycles with plot=0; total plot count 144; coins_left=10.
- Entry 0 = 16'h8000 | (158<<7) | 118 -> only (158,118), (159,118), (158,119), (159,119) plotted from that block; the other 12 cycles have plot=0.
- Second start pulse mid-pass -> ignored: one done, pixel count unchanged. resetn=0 during DRAW of entry 5 -> next cycle plot=0, busy=0, coins_left=0, mem_address=0.
- Back-to-back passes, entry 2 changed from 16'h8514 to 16'h0514 between them -> second pass draws entry 2 in 000; coins_left goes 10 -> 9.
